famicom_pad_scanner: RTL and testbench

- Parametrised successor to the single-port Famicom pad path: serially polls up to CHANNELS Famicom/SNES-style pads.
- All pads share one latch and one pulse line; each pad has its own data line.
- Outputs debounce-free, active-high button words with a one-cycle valid strobe.
- Sits between the board I/O pins and the core/loader, replacing direct pass-through of the pulse, latch and data signals.

---
 rtl/famicom_pad_scanner.sv | 169 ++++++++++++++++
 tb/tb_famicom_pad_scanner.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/famicom_pad_scanner.sv
// famicom_pad_scanner: serially polls up to CHANNELS Famicom/SNES pads that
// share one latch and one pulse line, each with its own data line.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   auto_mode               1 = poll every POLL_TICKS ticks, 0 = poll on request
//   poll_req                single-cycle poll request (manual mode)
//   pad_data[CHANNELS]      active-low serial data from each pad (asynchronous)
//   pad_latch, pad_pulse    shared latch and clock lines to the pads
//   buttons[CHANNELS*BITS]  channel c at [c*BITS +: BITS], bit 0 first shifted, 1 = pressed
//   buttons_valid           one-cycle strobe when buttons updates
//   busy                    poll in progress
//   present[CHANNELS]       last poll saw at least one pressed (low) bit on channel
module famicom_pad_scanner #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned BITS       = 8,
  parameter int unsigned CLK_DIV    = 300,
  parameter int unsigned POLL_TICKS = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     auto_mode,
  input  logic                     poll_req,
  input  logic [CHANNELS-1:0]      pad_data,
  output logic                     pad_latch,
  output logic                     pad_pulse,
  output logic [CHANNELS*BITS-1:0] buttons,
  output logic                     buttons_valid,
  output logic                     busy,
  output logic [CHANNELS-1:0]      present
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned IVL_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
  localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(POLL_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [DIV_W-1:0]          r_div;
  logic [IVL_W-1:0]          r_ivl;
  logic [BIT_W-1:0]          r_bit;
  logic                      r_lat_ph;
  logic                      r_pending;
  logic [CHANNELS-1:0]       r_sync1;
  logic [CHANNELS-1:0]       r_sync2;
  logic [CHANNELS*BITS-1:0]  r_shift;

  logic                      w_tick;
  logic                      w_ivl_wrap;
  logic                      w_start;
  logic [CHANNELS*BITS-1:0]  w_shift_nxt;
  logic [CHANNELS-1:0]       w_any;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_ivl_wrap = w_tick && (r_ivl == IVL_LAST);
  assign w_start    = (r_state == S_IDLE) &&
                      (auto_mode ? w_ivl_wrap : (poll_req || r_pending));

  // Per channel: shift the inverted sample in at the top so that after BITS
  // samples the first bit read sits at bit 0.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_shift_nxt[c*BITS +: BITS] = {~r_sync2[c], r_shift[c*BITS+1 +: BITS-1]};
    assign w_any[c]                    = |r_shift[c*BITS +: BITS];
  end

  // Synchroniser, tick divider, poll-interval counter and pending request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_div     <= '0;
      r_ivl     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_sync1 <= pad_data;
      r_sync2 <= r_sync1;

      // Restart on poll start so the first tick lands exactly CLK_DIV cycles later.
      if (w_start || w_tick) r_div <= '0;
      else                   r_div <= r_div + DIV_W'(1);

      // Interval counter runs on every tick, polling or not.
      if (w_tick) r_ivl <= (r_ivl == IVL_LAST) ? '0 : r_ivl + IVL_W'(1);

      // Requests arriving outside IDLE collapse into one deferred poll.
      if (auto_mode)                             r_pending <= 1'b0;
      else if (w_start)                          r_pending <= 1'b0;
      else if (poll_req && (r_state != S_IDLE))  r_pending <= 1'b1;
    end
  end

  // Poll sequencer with registered pad and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bit         <= '0;
      r_lat_ph      <= 1'b0;
      r_shift       <= '0;
      pad_latch     <= 1'b0;
      pad_pulse     <= 1'b0;
      busy          <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      present       <= '0;
    end else begin
      buttons_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
            r_lat_ph  <= 1'b0;
            r_bit     <= '0;
          end
        end
        S_LATCH: begin
          // Latch is held for two full tick periods.
          if (w_tick) begin
            if (r_lat_ph) begin
              r_state   <= S_LOW;
              pad_latch <= 1'b0;
            end else begin
              r_lat_ph  <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (w_tick) begin
            r_shift <= w_shift_nxt;
            if (r_bit == BIT_LAST) begin
              // busy spans exactly the 2*BITS+1 tick periods of the poll.
              r_state <= S_DONE;
              busy    <= 1'b0;
            end else begin
              r_state   <= S_HIGH;
              pad_pulse <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_state   <= S_LOW;
            pad_pulse <= 1'b0;
            r_bit     <= r_bit + BIT_W'(1);
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          buttons       <= r_shift;
          present       <= w_any;
          buttons_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_famicom_pad_scanner.sv
// Bench for famicom_pad_scanner: a Famicom-width two-pad instance and a
// single-pad SNES-width instance, each driven by behavioural pad models.
`timescale 1ns/1ps
module tb_famicom_pad_scanner;

  localparam int unsigned CH  = 2;
  localparam int unsigned BA  = 8;
  localparam int unsigned BB  = 16;
  localparam int unsigned DIV = 4;
  localparam int unsigned PT  = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             a_auto = 1'b0;
  logic             a_req = 1'b0;
  logic [CH-1:0]    a_data = '1;
  logic             a_latch, a_pulse, a_valid, a_busy;
  logic [CH*BA-1:0] a_buttons;
  logic [CH-1:0]    a_present;

  logic             b_auto = 1'b0;
  logic             b_req = 1'b0;
  logic [0:0]       b_data = 1'b1;
  logic             b_latch, b_pulse, b_valid, b_busy;
  logic [BB-1:0]    b_buttons;
  logic [0:0]       b_present;

  famicom_pad_scanner #(.CHANNELS(CH), .BITS(BA), .CLK_DIV(DIV), .POLL_TICKS(PT)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .auto_mode(a_auto), .poll_req(a_req), .pad_data(a_data),
    .pad_latch(a_latch), .pad_pulse(a_pulse), .buttons(a_buttons), .buttons_valid(a_valid),
    .busy(a_busy), .present(a_present));

  famicom_pad_scanner #(.CHANNELS(1), .BITS(BB), .CLK_DIV(DIV), .POLL_TICKS(100)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .auto_mode(b_auto), .poll_req(b_req), .pad_data(b_data),
    .pad_latch(b_latch), .pad_pulse(b_pulse), .buttons(b_buttons), .buttons_valid(b_valid),
    .busy(b_busy), .present(b_present));

  int checks = 0;
  int failures = 0;

  // Pad models: latch reloads to bit 0, each pulse rise advances one bit;
  // the line follows after a random sub-cycle-unaligned delay (low = pressed).
  logic [CH*BA-1:0] pat_a = '0;
  logic [BB-1:0]    pat_b = '0;
  int unsigned      idx_a = 0;
  int unsigned      idx_b = 0;
  real              dly_a, dly_b;

  always @(posedge a_latch or posedge a_pulse) begin
    if (a_latch) idx_a = 0; else idx_a = idx_a + 1;
    dly_a = real'($urandom_range(50, 25000)) / 1000.0;
    #(dly_a);
    a_data = (idx_a < BA) ? {~pat_a[4'(BA + idx_a)], ~pat_a[4'(idx_a)]} : 2'b11;
  end

  always @(posedge b_latch or posedge b_pulse) begin
    if (b_latch) idx_b = 0; else idx_b = idx_b + 1;
    dly_b = real'($urandom_range(50, 25000)) / 1000.0;
    #(dly_b);
    b_data[0] = (idx_b < BB) ? ~pat_b[4'(idx_b)] : 1'b1;
  end

  function automatic logic [CH-1:0] exp_present_a(input logic [CH*BA-1:0] p);
    return {|p[2*BA-1:BA], |p[BA-1:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_a();
    a_req = 1'b1; @(negedge clk); a_req = 1'b0;
  endtask

  task automatic req_b();
    b_req = 1'b1; @(negedge clk); b_req = 1'b0;
  endtask

  // Observe DUT A until three cycles past its valid strobe (bounded).
  task automatic measure_a(output int lat_n, output int pul_n, output int phi_n,
                           output int busy_n, output int val_n, output bit to);
    bit prev_p = 1'b0;
    int after = -1;
    lat_n = 0; pul_n = 0; phi_n = 0; busy_n = 0; val_n = 0; to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (a_latch) lat_n++;
      if (a_pulse) phi_n++;
      if (a_pulse && !prev_p) pul_n++;
      prev_p = a_pulse;
      if (a_busy) busy_n++;
      if (a_valid) begin val_n++; if (after < 0) after = 3; end
      if (after == 0) begin to = 1'b0; break; end
      if (after > 0) after--;
      @(negedge clk);
    end
  endtask

  task automatic measure_b(output int busy_n, output int val_n, output bit to);
    int after = -1;
    busy_n = 0; val_n = 0; to = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (b_busy) busy_n++;
      if (b_valid) begin val_n++; if (after < 0) after = 3; end
      if (after == 0) begin to = 1'b0; break; end
      if (after > 0) after--;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(5);
    checks++;
    if ({a_latch, a_pulse, a_busy, a_valid, a_present} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {a_latch, a_pulse, a_busy, a_valid, a_present});
    end
    checks++;
    if (a_buttons !== '0 || b_buttons !== '0) begin
      failures++;
      $display("FAIL reset_buttons: got a=%h b=%h expected 0", a_buttons, b_buttons);
    end
    reset_n = 1'b1;
    cyc(3);
    checks++;
    if ({a_latch, a_pulse, a_busy, a_valid, b_busy, b_latch} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 0", {a_latch, a_pulse, a_busy, a_valid, b_busy, b_latch});
    end
  endtask

  task automatic test_manual_poll();
    int lat_n, pul_n, phi_n, busy_n, val_n;
    bit to;
    pat_a = 16'h00A5;
    req_a();
    measure_a(lat_n, pul_n, phi_n, busy_n, val_n, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL manual_timeout: got no valid strobe, expected one"); end
    checks++;
    if (lat_n != int'(2*DIV)) begin failures++; $display("FAIL manual_latch_len: got %0d expected %0d", lat_n, 2*DIV); end
    checks++;
    if (pul_n != int'(BA-1)) begin failures++; $display("FAIL manual_pulse_count: got %0d expected %0d", pul_n, BA-1); end
    checks++;
    if (phi_n != int'((BA-1)*DIV)) begin failures++; $display("FAIL manual_pulse_len: got %0d expected %0d", phi_n, (BA-1)*DIV); end
    checks++;
    if (busy_n != int'((2*BA+1)*DIV)) begin failures++; $display("FAIL manual_busy_len: got %0d expected %0d", busy_n, (2*BA+1)*DIV); end
    checks++;
    if (val_n != 1) begin failures++; $display("FAIL manual_valid_len: got %0d expected 1", val_n); end
    checks++;
    if (a_buttons !== 16'h00A5) begin failures++; $display("FAIL manual_buttons: got %h expected 00a5", a_buttons); end
    checks++;
    if (a_present !== 2'b01) begin failures++; $display("FAIL manual_present: got %b expected 01", a_present); end
    for (int it = 0; it < 4; it++) begin
      pat_a = 16'($urandom);
      if (it == 1) pat_a[BA-1:0] = '0;
      cyc(int'($urandom_range(0, 5)));
      req_a();
      measure_a(lat_n, pul_n, phi_n, busy_n, val_n, to);
      checks++;
      if (a_buttons !== pat_a || a_present !== exp_present_a(pat_a)) begin
        failures++;
        $display("FAIL manual_rand%0d: got %h/%b expected %h/%b", it, a_buttons, a_present, pat_a, exp_present_a(pat_a));
      end
    end
  endtask

  task automatic test_snes();
    logic [BB-1:0] pats [3];
    int busy_n, val_n;
    bit to;
    pats[0] = 16'h8001;
    pats[1] = 16'h0003;
    pats[2] = 16'($urandom);
    for (int it = 0; it < 3; it++) begin
      pat_b = pats[it];
      req_b();
      measure_b(busy_n, val_n, to);
      checks++;
      if (to !== 1'b0 || b_buttons !== pat_b || b_present !== (|pat_b)) begin
        failures++;
        $display("FAIL snes_buttons%0d: got %h/%b timeout=%0d expected %h/%b", it, b_buttons, b_present, to, pat_b, |pat_b);
      end
      if (it == 0) begin
        checks++;
        if (busy_n != int'((2*BB+1)*DIV)) begin failures++; $display("FAIL snes_busy_len: got %0d expected %0d", busy_n, (2*BB+1)*DIV); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nval = 0;
    int k_v1 = -1;
    int k_b2 = -1;
    bit pb;
    pat_a = 16'($urandom);
    req_a();
    cyc(20); req_a();
    cyc(14); req_a();
    cyc(14); req_a();
    pb = a_busy;
    for (int k = 0; k < 300; k++) begin
      if (a_valid) begin nval++; if (k_v1 < 0) k_v1 = k; end
      if (a_busy && !pb && k_v1 >= 0 && k_b2 < 0) k_b2 = k;
      pb = a_busy;
      @(negedge clk);
    end
    checks++;
    if (nval != 2) begin failures++; $display("FAIL b2b_valid_count: got %0d expected 2", nval); end
    checks++;
    if (k_v1 < 0 || k_b2 != k_v1 + 1) begin failures++; $display("FAIL b2b_restart: got busy rise %0d valid %0d expected valid+1", k_b2, k_v1); end
    checks++;
    if (a_buttons !== pat_a) begin failures++; $display("FAIL b2b_buttons: got %h expected %h", a_buttons, pat_a); end
  endtask

  task automatic test_auto();
    int rises[$];
    int nval = 0;
    int k_off = -1;
    bit pb;
    pat_a = 16'($urandom);
    a_auto = 1'b1;
    pb = a_busy;
    for (int k = 0; k < 1200; k++) begin
      if (a_busy && !pb) rises.push_back(k);
      pb = a_busy;
      if (a_valid) nval++;
      if (rises.size() == 3 && k == rises[2] + 10) begin a_auto = 1'b0; k_off = k; end
      // Requests in auto mode (idle and busy, including just before the switch) must be ignored.
      a_req = a_auto && ((k % 37 == 5) || (rises.size() == 3 && k == rises[2] + 9));
      @(negedge clk);
    end
    a_req = 1'b0;
    checks++;
    if (rises.size() != 3) begin failures++; $display("FAIL auto_start_count: got %0d expected 3", rises.size()); end
    checks++;
    if (rises.size() < 3 || rises[1] - rises[0] != int'(PT*DIV) || rises[2] - rises[1] != int'(PT*DIV)) begin
      failures++;
      $display("FAIL auto_period: got rises %p expected spacing %0d", rises, PT*DIV);
    end
    checks++;
    if (nval != 3 || k_off < 0) begin failures++; $display("FAIL auto_valid_count: got %0d expected 3", nval); end
    checks++;
    if (a_buttons !== pat_a) begin failures++; $display("FAIL auto_buttons: got %h expected %h", a_buttons, pat_a); end
  endtask

  task automatic test_reset_mid_poll();
    int lat_n, pul_n, phi_n, busy_n, val_n;
    bit to;
    pat_a = 16'h5A3C;
    req_a();
    measure_a(lat_n, pul_n, phi_n, busy_n, val_n, to);
    checks++;
    if (a_buttons !== 16'h5A3C) begin failures++; $display("FAIL rstmid_pre_buttons: got %h expected 5a3c", a_buttons); end
    req_a();
    cyc(4);
    checks++;
    if (a_latch !== 1'b1) begin failures++; $display("FAIL rstmid_latch_pre: got %b expected 1", a_latch); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_latch, a_pulse, a_busy, a_valid, a_present} !== '0) begin
      failures++;
      $display("FAIL rstmid_ctrl: got %b expected 0", {a_latch, a_pulse, a_busy, a_valid, a_present});
    end
    checks++;
    if (a_buttons !== '0) begin failures++; $display("FAIL rstmid_buttons: got %h expected 0", a_buttons); end
    @(negedge clk);
    cyc(2);
    reset_n = 1'b1;
    val_n = 0; busy_n = 0;
    for (int k = 0; k < 200; k++) begin
      if (a_valid) val_n++;
      if (a_busy) busy_n++;
      @(negedge clk);
    end
    checks++;
    if (val_n != 0 || busy_n != 0) begin failures++; $display("FAIL rstmid_after: got valid=%0d busy=%0d expected 0/0", val_n, busy_n); end
  endtask

  task automatic test_async_data();
    bit seen_a, seen_b;
    for (int it = 0; it < 6; it++) begin
      pat_a = 16'($urandom);
      if (it == 2) pat_a[2*BA-1:BA] = '0;
      pat_b = 16'($urandom);
      cyc(int'($urandom_range(0, 7)));
      a_req = 1'b1; b_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;
      seen_a = 1'b0; seen_b = 1'b0;
      for (int k = 0; k < 300 && !(seen_a && seen_b); k++) begin
        if (a_valid) seen_a = 1'b1;
        if (b_valid) seen_b = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (!seen_a || $isunknown(a_buttons) || a_buttons !== pat_a || a_present !== exp_present_a(pat_a)) begin
        failures++;
        $display("FAIL async_a%0d: got %h/%b seen=%0d expected %h/%b", it, a_buttons, a_present, seen_a, pat_a, exp_present_a(pat_a));
      end
      checks++;
      if (!seen_b || $isunknown(b_buttons) || b_buttons !== pat_b) begin
        failures++;
        $display("FAIL async_b%0d: got %h seen=%0d expected %h", it, b_buttons, seen_b, pat_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_poll();
    test_snes();
    test_back_to_back();
    test_auto();
    test_reset_mid_poll();
    test_async_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion by 1ms expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
